// File: rtl/tdc_pkg.sv
// Shared constants for the TDC FIFO framer: state codes, frame byte indices, word fields.
// FRAMER_CHECKSUM_EN appends an XOR checksum byte to every frame.
package tdc_pkg;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FIFO_READ  = 3'd1;
    localparam logic [2:0] S_FIFO_LATCH = 3'd2;
    localparam logic [2:0] S_LOAD_BYTE  = 3'd3;
    localparam logic [2:0] S_STROBE     = 3'd4;
    localparam logic [2:0] S_GUARD      = 3'd5;
    localparam logic [2:0] S_WAIT_TX    = 3'd6;

    localparam logic [2:0] IDX_SYNC  = 3'd0;
    localparam logic [2:0] IDX_T1_HI = 3'd1;
    localparam logic [2:0] IDX_T1_LO = 3'd2;
    localparam logic [2:0] IDX_CD_HI = 3'd3;
    localparam logic [2:0] IDX_CD_LO = 3'd4;
    localparam logic [2:0] IDX_CSUM  = 3'd5;

`ifdef FRAMER_CHECKSUM_EN
    localparam logic [2:0] IDX_LAST = IDX_CSUM;
`else
    localparam logic [2:0] IDX_LAST = IDX_CD_LO;
`endif

    localparam int TIME1_LSB = 0;
    localparam int CALIB_LSB = 16;
    localparam int FIELD_W   = 16;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/tdc_fifo_framer_if.sv
// FIFO read port plus byte-wide TX handshake seen by the framer.
interface tdc_fifo_framer_if;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_new_data;

    modport master (input fifo_empty, fifo_dout, tx_busy,
                    output fifo_rd_en, tx_data, tx_new_data);
    modport slave  (output fifo_empty, fifo_dout, tx_busy,
                    input fifo_rd_en, tx_data, tx_new_data);
endinterface

// File: rtl/tdc_frame_mux.sv
// Combinational frame byte select; FRAMER_CHECKSUM_EN adds the XOR checksum byte.
module tdc_frame_mux
    import tdc_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic [31:0] word_i,
    input  logic [2:0]  idx_i,
    output logic [7:0]  byte_o
);
    logic [FIELD_W-1:0] time1;
    logic [FIELD_W-1:0] calib;

    assign time1 = word_i[TIME1_LSB +: FIELD_W];
    assign calib = word_i[CALIB_LSB +: FIELD_W];

    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            IDX_SYNC:  byte_o = SYNC_BYTE;
            IDX_T1_HI: byte_o = time1[15:8];
            IDX_T1_LO: byte_o = time1[7:0];
            IDX_CD_HI: byte_o = calib[15:8];
            IDX_CD_LO: byte_o = calib[7:0];
`ifdef FRAMER_CHECKSUM_EN
            IDX_CSUM:  byte_o = time1[15:8] ^ time1[7:0] ^ calib[15:8] ^ calib[7:0];
`endif
            default:   byte_o = 8'h00;
        endcase
    end
endmodule

// File: rtl/tdc_fifo_framer.sv
// Drains TDC words from the measurement FIFO and sends each as a byte frame to the serial TX.
// FRAMER_CHECKSUM_EN selects the 6-byte frame with trailing XOR checksum.
module tdc_fifo_framer
    import tdc_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         GUARD_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    tdc_fifo_framer_if.master         bus,
    output logic                      frame_active,
    output logic [15:0]               frames_sent
);
    localparam logic [1:0] GUARD_INIT = 2'(GUARD_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        rd_en_q, rd_en_d;
    logic        new_q, new_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        active_q, active_d;
    logic [15:0] frames_q, frames_d;
    logic [1:0]  guard_q, guard_d;

    logic [2:0]  idx_inc;
    logic [2:0]  mux_idx;
    logic [7:0]  mux_byte;

    // tx_data is loaded on entry to LOAD_BYTE so it is stable a cycle before the strobe.
    assign idx_inc = idx_q + 3'd1;
    assign mux_idx = (state_q == S_FIFO_LATCH) ? IDX_SYNC : idx_inc;

    tdc_frame_mux #(.SYNC_BYTE(SYNC_BYTE)) u_mux (
        .word_i (word_q),
        .idx_i  (mux_idx),
        .byte_o (mux_byte)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        rd_en_d   = 1'b0;
        new_d     = 1'b0;
        tx_data_d = tx_data_q;
        active_d  = active_q;
        frames_d  = frames_q;
        guard_d   = guard_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !bus.fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_FIFO_READ;
                end
            end
            S_FIFO_READ: state_d = S_FIFO_LATCH;
            S_FIFO_LATCH: begin
                word_d    = bus.fifo_dout;
                idx_d     = IDX_SYNC;
                active_d  = 1'b1;
                tx_data_d = mux_byte;
                state_d   = S_LOAD_BYTE;
            end
            S_LOAD_BYTE: begin
                if (!bus.tx_busy) begin
                    new_d   = 1'b1;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                guard_d = GUARD_INIT;
                state_d = S_GUARD;
            end
            // TX raises busy a few cycles after the strobe; don't trust it until then.
            S_GUARD: begin
                if (guard_q == 2'd0) state_d = S_WAIT_TX;
                else                 guard_d = guard_q - 2'd1;
            end
            S_WAIT_TX: begin
                if (!bus.tx_busy) begin
                    if (idx_q == IDX_LAST) begin
                        frames_d = frames_q + 16'd1;
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        idx_d     = idx_inc;
                        tx_data_d = mux_byte;
                        state_d   = S_LOAD_BYTE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            word_q    <= 32'd0;
            rd_en_q   <= 1'b0;
            new_q     <= 1'b0;
            tx_data_q <= 8'h00;
            active_q  <= 1'b0;
            frames_q  <= 16'd0;
            guard_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            rd_en_q   <= rd_en_d;
            new_q     <= new_d;
            tx_data_q <= tx_data_d;
            active_q  <= active_d;
            frames_q  <= frames_d;
            guard_q   <= guard_d;
        end
    end

    assign bus.fifo_rd_en  = rd_en_q;
    assign bus.tx_new_data = new_q;
    assign bus.tx_data     = tx_data_q;
    assign frame_active    = active_q;
    assign frames_sent     = frames_q;

endmodule

// File: doc/tdc_fifo_framer.md
Name: tdc_fifo_framer

Overview:
- Drains 32-bit TDC measurement words ({calib_diff[15:0], time1[15:0]}) from the measurement FIFO, the far end of the TDC controller's write port.
- Frames each word as a fixed byte packet and feeds it to the byte-wide serial transmitter (UART/host link) through a new_data/busy handshake.
- Sits between the FIFO read port and the serial TX, one frame per FIFO word.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- GUARD_CYCLES, 1, cycles after a tx_new_data strobe during which tx_busy is ignored (TX busy rise latency); range 1..3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  1 = drain FIFO; 0 = finish current frame, then idle
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  32  FIFO read data, valid exactly 1 cycle after fifo_rd_en
- fifo_rd_en  out  1  single-cycle read strobe
- tx_busy  in  1  transmitter busy
- tx_data  out  8  byte to transmit
- tx_new_data  out  1  single-cycle byte strobe
- frame_active  out  1  high from FIFO read until last byte accepted
- frames_sent  out  16  count of completed frames, wraps 16'hFFFF -> 0

Behaviour:
- Single clock clk; reset synchronous active-high on rst; all state in registers updated on posedge clk.
- Reset values: fifo_rd_en=0, tx_new_data=0, tx_data=8'h00, frame_active=0, frames_sent=0, state=IDLE, byte index=0, word register=0.
- States: IDLE, FIFO_READ, FIFO_LATCH, LOAD_BYTE, STROBE, GUARD, WAIT_TX.
- IDLE: if enable && !fifo_empty -> FIFO_READ with fifo_rd_en=1 for exactly one cycle.
- FIFO_READ: rd_en drops; -> FIFO_LATCH.
- FIFO_LATCH: capture fifo_dout into word register, byte index=0, frame_active=1; -> LOAD_BYTE.
- Frame byte order: index 0 SYNC_BYTE, 1 time1[15:8], 2 time1[7:0], 3 calib_diff[15:8], 4 calib_diff[7:0], 5 checksum (feature only).
- LOAD_BYTE: drive tx_data for current index; if !tx_busy -> STROBE, else stay. tx_data is stable at least one cycle before and during the strobe.
- STROBE: tx_new_data=1 for one cycle; -> GUARD.
- GUARD: tx_new_data=0; hold GUARD_CYCLES cycles ignoring tx_busy; -> WAIT_TX.
- WAIT_TX: when !tx_busy: if index is last -> frames_sent+1, frame_active=0, IDLE; else index+1 -> LOAD_BYTE.
- Never more than one strobe per accepted byte; never strobe while tx_busy=1.
- enable deassert mid-frame: frame completes; no new FIFO read until enable=1.
- fifo_empty rising during a frame: no effect; checked only in IDLE.
- Back-to-back words: next read issued the cycle after returning to IDLE; no bytes dropped.
- fifo_rd_en never asserted while fifo_empty=1.
- rst mid-frame: aborts immediately to reset values; partial frame not resumed; captured word lost.

Optional Feature:
- Macro FRAMER_CHECKSUM_EN.
- Defined: 6-byte frame; byte 5 = XOR of bytes 1..4 (sync excluded).
- Undefined: 5-byte frame; last index is 4; no checksum logic.

Decomposition:
- Shared package tdc_pkg: state encoding localparams, frame index constants (IDX_SYNC..IDX_CSUM), TDC word field positions (TIME1 = [15:0], CALIB_DIFF = [31:16]), default SYNC_BYTE.
- One natural sub-module: tdc_frame_mux, a combinational byte select plus checksum from word register and index. All sequencing stays in the top.

Test Plan:
- Single word 32'h1234_05D0 in FIFO, tx idle -> strobes carry A5,05,D0,12,34 (+ checksum 05^D0^12^34=F3 with FRAMER_CHECKSUM_EN); frames_sent=1; exactly one fifo_rd_en pulse.
- tx_busy held high 20 cycles after each strobe -> no new strobe until busy falls; byte order unchanged; no duplicate strobes.
- Three words queued back-to-back -> 3 complete frames in order; fifo_rd_en pulses =3; never asserted with fifo_empty=1.
- enable dropped after byte 2 of a frame -> remaining bytes sent, then idle with FIFO non-empty; enable=1 resumes with the next word.
- rst asserted after byte 3 -> next cycle all outputs at reset values; after release, the next frame starts with A5 from a fresh FIFO word.
- frames_sent preset near wrap via 65537 frames (or forced) -> 16'hFFFF -> 16'h0000.
